// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe_reg_ahr pipeline register chain.
package pipe_pkg;

  // Width needed to count 0..depth valid stages inclusive.
  function automatic int occWidth(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_ahr.sv
// One pipeline stage: valid/data registers with load-or-hold, valid-gated data load and flush clear.
module pipe_stage_ahr
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic             validNext_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Flush only clears the valid bit; data is retained so a bubble never disturbs out_data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o     = valid_q;
  assign validNext_o = valid_d;
  assign data_o      = data_q;

endmodule

// File: rtl/pipe_reg_ahr.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse, synchronous flush and occupancy count.
module pipe_reg_ahr
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [occWidth(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occWidth(DEPTH);

  logic [DEPTH-1:0] stageValid;
  logic [DEPTH-1:0] stageValidNext;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] srcValid;
  logic [WIDTH-1:0] stageData [DEPTH];
  logic [WIDTH-1:0] srcData   [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;

  // Ready ripples back from the output; an empty stage always advances so bubbles collapse.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = !stageValid[DEPTH-1] | out_ready;
    adv[DEPTH-1] = chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      chain  = !stageValid[i] | chain;
      adv[i] = chain;
    end
  end

  always_comb begin
    srcValid   = '0;
    srcValid[0] = in_valid;
    srcData[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      srcValid[i] = stageValid[i-1];
      srcData[i]  = stageData[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gStage
    pipe_stage_ahr #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) uStage (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .adv_i       (adv[g]),
      .valid_i     (srcValid[g]),
      .data_i      (srcData[g]),
      .valid_o     (stageValid[g]),
      .validNext_o (stageValidNext[g]),
      .data_o      (stageData[g])
    );
  end

  // Counting next-state valids keeps the registered count aligned with the stage registers.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(stageValidNext[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign in_ready  = adv[0] & !flush;
  assign out_valid = stageValid[DEPTH-1];
  assign out_data  = stageData[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_ahr.sv
// Scoreboard bench for pipe_reg_ahr (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5) using directed vectors.
module tb_pipe_reg_ahr;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  int checks    = 0;
  int errors    = 0;
  int delivered = 0;
  int base;
  int w;
  int n;
  logic acc;
  logic [7:0] expQ[$];
  logic [7:0] expWord;

  pipe_reg_ahr #(
    .WIDTH     (8),
    .DEPTH     (4),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge; an accepted word enters the scoreboard.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic oR,
                               input logic fl, output logic accepted);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = oR;
    flush     = fl;
    @(negedge clk);
    accepted = v && (in_ready === 1'b1);
    if (accepted) expQ.push_back(d);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every output transfer must match the oldest accepted word.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL outData: got %h, expected no word", out_data);
      end else begin
        expWord = expQ.pop_front();
        if (out_data !== expWord) begin
          errors++;
          $display("[TB] FAIL outData: got %h, expected %h", out_data, expWord);
        end
      end
      delivered++;
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset asserted between edges takes effect immediately.
    #2 rst = 1'b1;
    #1;
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstOutData", out_data, 8'hA5);
    checkOutput("rstOccupancy", occupancy, 0);
    checkOutput("rstInReady", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] streaming");
    base = delivered;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i < 16, 8'(i + 1), 1'b1, 1'b0, acc);
      if (i == 3) checkOutput("latencyNotYet", out_valid, 0);
      if (i == 4) checkOutput("latencyFirstWord", out_data, 8'h01);
      if (i >= 4) checkOutput($sformatf("streamValid%0d", i), out_valid, 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("streamDelivered", delivered - base, 16);
    checkOutput("streamOccupancy", occupancy, 0);
    checkOutput("streamQueueEmpty", expQ.size(), 0);

    $display("[TB] back-pressure");
    base = delivered;
    w = 0;
    n = 0;
    while (w < 6 && n < 40) begin
      applyStimulus(1'b1, 8'(8'h21 + w), n >= 6, 1'b0, acc);
      if (acc) w++;
      if (n == 4) begin
        checkOutput("bpFullInReady", in_ready, 0);
        checkOutput("bpFullOccupancy", occupancy, 4);
        checkOutput("bpFullOutValid", out_valid, 1);
        checkOutput("bpFullOutData", out_data, 8'h21);
      end
      if (n == 5) checkOutput("bpStillStalled", in_ready, 0);
      n++;
    end
    checkOutput("bpAllSent", w, 6);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("bpDelivered", delivered - base, 6);
    checkOutput("bpQueueEmpty", expQ.size(), 0);

    $display("[TB] bubble collapse");
    base = delivered;
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, acc);
    checkOutput("bubbleAccA", acc, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0, acc);
    checkOutput("bubbleAccB", acc, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("bubbleOccupancy", occupancy, 2);
    checkOutput("bubbleInReady", in_ready, 1);
    checkOutput("bubbleHeadData", out_data, 8'h31);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("bubbleOutA", out_valid, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("bubbleOutB", out_valid, 1);
    checkOutput("bubbleOutBData", out_data, 8'h32);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("bubbleDrained", out_valid, 0);
    checkOutput("bubbleDelivered", delivered - base, 2);

    $display("[TB] flush");
    base = delivered;
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("preFlushOccupancy", occupancy, 3);
    applyStimulus(1'b1, 8'h4F, 1'b0, 1'b1, acc);
    checkOutput("flushInReady", in_ready, 0);
    checkOutput("flushOutValidHeld", out_valid, 1);
    expQ.delete();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("postFlushOccupancy", occupancy, 0);
    checkOutput("postFlushOutValid", out_valid, 0);
    checkOutput("postFlushOutData", out_data, 8'h41);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("flushDelivered", delivered - base, 0);

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h51 + i), 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("preRstOccupancy", occupancy, 4);
    checkOutput("preRstInReady", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", out_valid, 0);
    checkOutput("midRstOutData", out_data, 8'hA5);
    checkOutput("midRstOccupancy", occupancy, 0);
    checkOutput("midRstInReady", in_ready, 1);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    base = delivered;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h61 + i), 1'b1, 1'b0, acc);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
    checkOutput("resumeDelivered", delivered - base, 4);
    checkOutput("resumeQueueEmpty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
